param_bus_datapath: RTL
=======================

PARAM_BUS_DATAPATH -- requirements
Module: param_bus_datapath

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath/bus width in bits (8..64).
REQ-002 SHALL provide parameter NREGS, default 16, number of general registers (2..32).
REQ-003 SHALL provide parameter MULDIV_EN, default 1, enabling multi-cycle multiply/divide.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 reg_out  input  NREGS  one-hot drive of general register i onto bus.
REQ-007 reg_in  input  NREGS  load enable of general register i from bus.
REQ-008 pc_out, mdr_out, hi_out, lo_out, zhi_out, zlo_out  input  1 each  bus drive enables.
REQ-009 pc_in, mdr_in, mar_in, ir_in, hi_in, lo_in, y_in, z_in  input  1 each  load enables.
REQ-010 read  input  1  MDR source select: 1 = mem_data_in, 0 = bus.
REQ-011 mem_data_in  input  WIDTH  memory read data.
REQ-012 inc_pc  input  1  with z_in, Z low loads bus+1 instead of the ALU result.
REQ-013 alu_op  input  4  ALU operation code.
REQ-014 start  input  1  single-cycle request to launch multiply/divide.
REQ-015 busy  output  1  multi-cycle operation in progress.
REQ-016 done  output  1  one-cycle pulse on multi-cycle completion.
REQ-017 bus_err  output  1  more than one bus drive enable asserted this cycle.
REQ-018 bus  output  WIDTH  current bus value.
REQ-019 mar_val, ir_val  output  WIDTH each  MAR and IR contents.
REQ-020 z_val  output  2*WIDTH  Z register contents.

Function
REQ-021 Bus SHALL equal the single enabled source; with zero or more than one enable, bus SHALL be 0 and bus_err SHALL equal (count>1), combinationally.
REQ-022 Every register SHALL load on the rising clk edge when its enable is high; a register may load from the bus it drives in the same cycle.
REQ-023 Combinational alu_op codes SHALL be: 0 add, 1 sub (Y-bus), 2 and, 3 or, 4 logical shift right, 5 shift left, 6 rotate right, 7 rotate left (shift amount bus[log2(WIDTH)-1:0], operand Y), 10 negate bus, 11 not bus; codes 12-15 SHALL yield 0.
REQ-024 For combinational ops z_in SHALL load Z low with the WIDTH-bit result (carry discarded) and Z high with 0.
REQ-025 inc_pc with z_in SHALL load Z = {0, bus+1} regardless of alu_op, wrapping all-ones to 0.
REQ-026 Codes 8 (unsigned multiply Y*bus) and 9 (unsigned divide Y/bus) SHALL start only on start=1 while busy=0, latching operands that cycle; z_in in that cycle SHALL be ignored.
REQ-027 Sequencer states SHALL be IDLE, RUN, DONE: IDLE->RUN on valid start; RUN lasts exactly WIDTH cycles (one bit per cycle); RUN->DONE; DONE->IDLE after one cycle.
REQ-028 busy SHALL be 1 in RUN; done SHALL be 1 in DONE only; Z SHALL load in the RUN->DONE edge.
REQ-029 Multiply result SHALL be the full 2*WIDTH product in Z {high,low}.
REQ-030 Divide SHALL place remainder in Z high, quotient in Z low; divisor 0 SHALL give quotient all-ones, remainder = dividend.
REQ-031 start while busy, or with alu_op not 8/9, SHALL be ignored; z_in while busy or done SHALL be ignored.
REQ-032 With MULDIV_EN=0, codes 8/9 SHALL behave as 12-15 and busy/done SHALL stay 0.
REQ-033 Total latency start to done SHALL be WIDTH+1 cycles.

Reset
REQ-034 reset SHALL asynchronously clear all registers, Y, Z, HI, LO, PC, IR, MAR, MDR, sequencer to IDLE, busy=0, done=0.
REQ-035 reset during RUN SHALL abort the operation with no Z update and no done pulse.

Verification
REQ-036 reg_in[3]=1, mdr_out with read loading 0x0000_00A5 earlier -> R3=0x0000_00A5, bus_err=0.
REQ-037 reg_out[1]=1 and pc_out=1 together -> bus=0, bus_err=1.
REQ-038 Y=0xFFFF_FFFF, bus=1, alu_op=0, z_in -> Z=0x0000_0000_0000_0000; inc_pc with bus=0xFFFF_FFFF -> Z low 0.
REQ-039 Y=0xFFFF_FFFF, bus=0xFFFF_FFFF, alu_op=8, start -> busy 32 cycles, done on cycle 33, Z=0xFFFF_FFFE_0000_0001.
REQ-040 Y=100, bus=7, alu_op=9, start -> Z high=2, low=14; bus=0 -> Z high=100, low=0xFFFF_FFFF.
REQ-041 reset asserted mid-RUN, then deasserted -> busy=0, done never pulses, Z=0.

Source files
------------

// File: rtl/param_bus_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : param_bus_datapath
//  Purpose  : Single-bus CPU datapath with a general register file, PC, MDR,
//             MAR, IR, HI/LO, Y/Z ALU registers, and an optional bit-serial
//             multiply/divide sequencer (one result bit per clock).
//  Revision : 1.0 - initial release
// ============================================================================
module param_bus_datapath #(
    parameter int WIDTH     = 32,
    parameter int NREGS     = 16,
    parameter int MULDIV_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREGS-1:0]     reg_out,
    input  logic [NREGS-1:0]     reg_in,
    input  logic                 pc_out,
    input  logic                 mdr_out,
    input  logic                 hi_out,
    input  logic                 lo_out,
    input  logic                 zhi_out,
    input  logic                 zlo_out,
    input  logic                 pc_in,
    input  logic                 mdr_in,
    input  logic                 mar_in,
    input  logic                 ir_in,
    input  logic                 hi_in,
    input  logic                 lo_in,
    input  logic                 y_in,
    input  logic                 z_in,
    input  logic                 read,
    input  logic [WIDTH-1:0]     mem_data_in,
    input  logic                 inc_pc,
    input  logic [3:0]           alu_op,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 bus_err,
    output logic [WIDTH-1:0]     bus,
    output logic [WIDTH-1:0]     mar_val,
    output logic [WIDTH-1:0]     ir_val,
    output logic [2*WIDTH-1:0]   z_val
);

    localparam int c_SH_W  = $clog2(WIDTH);
    localparam int c_CNT_W = $clog2(WIDTH);
    localparam int c_NSRC  = NREGS + 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_regs [NREGS];
    logic [WIDTH-1:0]     r_pc, r_mdr, r_mar, r_ir, r_hi, r_lo, r_y;
    logic [2*WIDTH-1:0]   r_z;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_opb;
    logic                 r_is_div;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [c_NSRC-1:0]    w_sel;
    logic                 w_multi, w_single;
    logic [WIDTH-1:0]     w_bus_raw;
    logic [WIDTH-1:0]     w_alu;
    logic [c_SH_W-1:0]    w_amt;
    logic [31:0]          w_rot, w_rinv;
    logic [2*WIDTH-1:0]   w_z_comb;
    logic                 w_start_ok, w_z_load, w_last;
    logic [2*WIDTH-1:0]   w_acc_mul;
    logic [WIDTH:0]       w_dshift;
    logic                 w_dge;
    logic [WIDTH-1:0]     w_dsub, w_rem_nxt, w_quo_nxt;

    // Bus arbitration: exactly one enable drives, anything else floats to zero
    assign w_sel    = {reg_out, pc_out, mdr_out, hi_out, lo_out, zhi_out, zlo_out};
    assign w_multi  = (w_sel & (w_sel - c_NSRC'(1))) != '0;
    assign w_single = (w_sel != '0) && !w_multi;
    assign bus      = w_single ? w_bus_raw : '0;
    assign bus_err  = w_multi;

    // OR together all enabled sources; only meaningful when a single one is on
    always_comb begin
        w_bus_raw = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_out[i]) w_bus_raw = w_bus_raw | r_regs[i];
        end
        if (pc_out)  w_bus_raw = w_bus_raw | r_pc;
        if (mdr_out) w_bus_raw = w_bus_raw | r_mdr;
        if (hi_out)  w_bus_raw = w_bus_raw | r_hi;
        if (lo_out)  w_bus_raw = w_bus_raw | r_lo;
        if (zhi_out) w_bus_raw = w_bus_raw | r_z[2*WIDTH-1:WIDTH];
        if (zlo_out) w_bus_raw = w_bus_raw | r_z[WIDTH-1:0];
    end

    // Rotates reduce the amount modulo WIDTH so non-power-of-two widths still wrap
    assign w_amt  = bus[c_SH_W-1:0];
    assign w_rot  = 32'(w_amt) % 32'(WIDTH);
    assign w_rinv = 32'(WIDTH) - w_rot;

    // Single-cycle ALU, operand A is Y and operand B is the bus
    always_comb begin
        w_alu = '0;
        case (alu_op)
            4'd0:    w_alu = r_y + bus;
            4'd1:    w_alu = r_y - bus;
            4'd2:    w_alu = r_y & bus;
            4'd3:    w_alu = r_y | bus;
            4'd4:    w_alu = r_y >> w_amt;
            4'd5:    w_alu = r_y << w_amt;
            4'd6:    w_alu = (r_y >> w_rot) | (r_y << w_rinv);
            4'd7:    w_alu = (r_y << w_rot) | (r_y >> w_rinv);
            4'd10:   w_alu = '0 - bus;
            4'd11:   w_alu = ~bus;
            default: w_alu = '0;
        endcase
    end

    assign w_z_comb   = inc_pc ? {{WIDTH{1'b0}}, bus + WIDTH'(1)} : {{WIDTH{1'b0}}, w_alu};
    assign w_start_ok = (MULDIV_EN != 0) && start && (r_state == S_IDLE)
                        && ((alu_op == 4'd8) || (alu_op == 4'd9));
    assign w_z_load   = z_in && (r_state == S_IDLE) && !w_start_ok;
    assign w_last     = (r_state == S_RUN) && (r_cnt == c_CNT_W'(WIDTH - 1));

    // One serial step: shift-add multiply, restoring divide
    assign w_acc_mul = r_acc + (r_opb[0] ? r_mcand : '0);
    assign w_dshift  = {r_acc[2*WIDTH-1:WIDTH], r_opb[WIDTH-1]};
    assign w_dge     = w_dshift >= {1'b0, r_mcand[WIDTH-1:0]};
    assign w_dsub    = w_dshift[WIDTH-1:0] - r_mcand[WIDTH-1:0];
    assign w_rem_nxt = w_dge ? w_dsub : w_dshift[WIDTH-1:0];
    assign w_quo_nxt = {r_opb[WIDTH-2:0], w_dge};

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Sequencer next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // General register file, loaded from the bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (reg_in[i]) r_regs[i] <= bus;
            end
        end
    end

    // Special-purpose registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= '0;
            r_mdr <= '0;
            r_mar <= '0;
            r_ir  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_y   <= '0;
        end else begin
            if (pc_in)  r_pc  <= bus;
            if (mdr_in) r_mdr <= read ? mem_data_in : bus;
            if (mar_in) r_mar <= bus;
            if (ir_in)  r_ir  <= bus;
            if (hi_in)  r_hi  <= bus;
            if (lo_in)  r_lo  <= bus;
            if (y_in)   r_y   <= bus;
        end
    end

    // Z takes the serial result on the final step, otherwise the ALU result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_z <= '0;
        end else if (w_last) begin
            r_z <= r_is_div ? {w_rem_nxt, w_quo_nxt} : w_acc_mul;
        end else if (w_z_load) begin
            r_z <= w_z_comb;
        end
    end

    // Multiply/divide working registers: operands latched at start, stepped in RUN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
        end else if (w_start_ok) begin
            r_is_div <= (alu_op == 4'd9);
            r_cnt    <= '0;
            r_acc    <= '0;
            if (alu_op == 4'd9) begin
                r_mcand <= {{WIDTH{1'b0}}, bus};
                r_opb   <= r_y;
            end else begin
                r_mcand <= {{WIDTH{1'b0}}, r_y};
                r_opb   <= bus;
            end
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (r_is_div) begin
                r_acc[2*WIDTH-1:WIDTH] <= w_rem_nxt;
                r_opb                  <= w_quo_nxt;
            end else begin
                r_acc   <= w_acc_mul;
                r_mcand <= r_mcand << 1;
                r_opb   <= r_opb >> 1;
            end
        end
    end

    assign mar_val = r_mar;
    assign ir_val  = r_ir;
    assign z_val   = r_z;

endmodule
`default_nettype wire
